// File: rtl/divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, signed or unsigned.
// Divide-by-zero and the signed overflow case bypass the iteration and finish in one cycle.
module divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] rem_reg, quo_reg, dvs_reg;
  logic             neg_q_reg, neg_r_reg;
  logic [WIDTH-1:0] quotient_reg, remainder_reg;
  logic             dbz_reg;

  logic             accept, div_zero, overflow, last, qbit;
  logic [WIDTH-1:0] dvd_mag, dvs_mag, rem_step, quo_step, q_final, r_final;
  logic [WIDTH:0]   shifted, diff;

  assign accept   = start && (state_reg != RUN);
  assign div_zero = (divisor == '0);
  assign overflow = is_signed && (dividend == MOST_NEG) && (divisor == '1);
  // Magnitude of the most-negative value still fits as an unsigned WIDTH-bit number.
  assign dvd_mag  = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
  assign dvs_mag  = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

  // Trial subtract; a borrow in the top bit means restore the shifted remainder.
  assign shifted  = {rem_reg, quo_reg[WIDTH-1]};
  assign diff     = shifted - {1'b0, dvs_reg};
  assign qbit     = ~diff[WIDTH];
  assign rem_step = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quo_step = {quo_reg[WIDTH-2:0], qbit};
  assign last     = (count_reg == CW'(WIDTH-1));
  assign q_final  = neg_q_reg ? -quo_step : quo_step;
  assign r_final  = neg_r_reg ? -rem_step : rem_step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (start) state_next = (div_zero || overflow) ? DONE : RUN;
        else       state_next = IDLE;
      end
      RUN:     state_next = last ? DONE : RUN;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg == RUN);
    done = (state_reg == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg     <= '0;
      rem_reg       <= '0;
      quo_reg       <= '0;
      dvs_reg       <= '0;
      neg_q_reg     <= 1'b0;
      neg_r_reg     <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dbz_reg       <= 1'b0;
    end else if (accept) begin
      count_reg <= '0;
      rem_reg   <= '0;
      quo_reg   <= dvd_mag;
      dvs_reg   <= dvs_mag;
      neg_q_reg <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      neg_r_reg <= is_signed & dividend[WIDTH-1];
      if (div_zero) begin
        quotient_reg  <= '1;
        remainder_reg <= dividend;
        dbz_reg       <= 1'b1;
      end else if (overflow) begin
        quotient_reg  <= dividend;
        remainder_reg <= '0;
        dbz_reg       <= 1'b0;
      end
    end else if (state_reg == RUN) begin
      count_reg <= count_reg + CW'(1);
      rem_reg   <= rem_step;
      quo_reg   <= quo_step;
      if (last) begin
        quotient_reg  <= q_final;
        remainder_reg <= r_final;
        dbz_reg       <= 1'b0;
      end
    end
  end

  assign quotient    = quotient_reg;
  assign remainder   = remainder_reg;
  assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: stimulus pushes expected results, a monitor
// pops and compares on every done pulse and checks results hold in between.
module tb_divider;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       is_signed = 1'b0;
  logic [7:0] dividend = '0;
  logic [7:0] divisor = '0;
  logic       busy, done, div_by_zero;
  logic [7:0] quotient, remainder;

  divider #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
    int         done_at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   edge_cnt = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  logic [7:0] held_q = '0, held_r = '0;
  logic       held_z = 1'b0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edge_cnt);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      held_q = '0; held_r = '0; held_z = 1'b0;
    end else if (done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 64'(done), 64'(0));
      end else begin
        mon_e = sb.pop_front();
        check("quotient", 64'(quotient), 64'(mon_e.q));
        check("remainder", 64'(remainder), 64'(mon_e.r));
        check("div_by_zero", 64'(div_by_zero), 64'(mon_e.z));
        check("done_cycle", 64'(edge_cnt), 64'(mon_e.done_at));
        check("busy_in_done", 64'(busy), 64'(0));
        $display("op done at edge %0d: q=%02h r=%02h dbz=%0b", edge_cnt, quotient, remainder, div_by_zero);
        held_q = mon_e.q; held_r = mon_e.r; held_z = mon_e.z;
      end
    end else begin
      check("results_held", 64'({quotient, remainder, div_by_zero}), 64'({held_q, held_r, held_z}));
    end
  end

  // Drive one start at the current negedge; accepted on the following rising edge.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic sgn,
                       input logic [7:0] eq, input logic [7:0] er, input logic ez, input bit quick);
    int acc;
    start = 1'b1; dividend = a; divisor = b; is_signed = sgn;
    acc = edge_cnt + 1;
    sb.push_back('{q: eq, r: er, z: ez, done_at: acc + (quick ? 0 : 8)});
    @(negedge clk);
    start = 1'b0; dividend = 8'($urandom); divisor = 8'($urandom); is_signed = 1'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    #1;
    check("drain_timeout", 64'(sb.size()), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, pending=%0d", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    #2;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_quotient", 64'(quotient), 64'(0));
    check("rst_remainder", 64'(remainder), 64'(0));
    check("rst_dbz", 64'(div_by_zero), 64'(0));

    // Release reset and start on the very same cycle.
    @(negedge clk);
    rst_n = 1'b1;
    issue(8'd100, 8'd7, 1'b0, 8'd14, 8'd2, 1'b0, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      check($sformatf("busy_cycle%0d", k), 64'(busy), 64'(k <= 8));
      if (k < 9) @(negedge clk);
    end
    drain();

    @(negedge clk); issue(8'hF9, 8'h02, 1'b1, 8'hFD, 8'hFF, 1'b0, 1'b0); drain();
    @(negedge clk); issue(8'h55, 8'h00, 1'b0, 8'hFF, 8'h55, 1'b1, 1'b1); drain();
    @(negedge clk); issue(8'h55, 8'h00, 1'b1, 8'hFF, 8'h55, 1'b1, 1'b1); drain();
    @(negedge clk); issue(8'h80, 8'hFF, 1'b1, 8'h80, 8'h00, 1'b0, 1'b1); drain();
    @(negedge clk); issue(8'h80, 8'hFF, 1'b0, 8'h00, 8'h80, 1'b0, 1'b0); drain();
    @(negedge clk); issue(8'h07, 8'hFE, 1'b1, 8'hFD, 8'h01, 1'b0, 1'b0); drain();
    @(negedge clk); issue(8'h80, 8'h03, 1'b1, 8'hD6, 8'hFE, 1'b0, 1'b0); drain();
    @(negedge clk); issue(8'hFF, 8'h01, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0); drain();
    @(negedge clk); issue(8'h9C, 8'hF9, 1'b1, 8'h0E, 8'hFE, 1'b0, 1'b0); drain();

    // Start during RUN must be ignored.
    @(negedge clk);
    issue(8'd200, 8'd3, 1'b0, 8'd66, 8'd2, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    start = 1'b1; dividend = 8'd9; divisor = 8'd4; is_signed = 1'b0;
    @(negedge clk);
    start = 1'b0;
    drain();

    // Reset in the middle of an operation: outputs clear at once, no done afterwards.
    @(negedge clk);
    start = 1'b1; dividend = 8'd50; divisor = 8'd7; is_signed = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_done", 64'(done), 64'(0));
    check("arst_quotient", 64'(quotient), 64'(0));
    check("arst_remainder", 64'(remainder), 64'(0));
    check("arst_dbz", 64'(div_by_zero), 64'(0));
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("no_done_after_abort", 64'(sb.size()), 64'(0));

    // Back-to-back: start held high through DONE.
    start = 1'b1; dividend = 8'd13; divisor = 8'd5; is_signed = 1'b0;
    acc = edge_cnt + 1;
    sb.push_back('{q: 8'd2, r: 8'd3, z: 1'b0, done_at: acc + 8});
    sb.push_back('{q: 8'd15, r: 8'd15, z: 1'b0, done_at: acc + 17});
    @(negedge clk);
    dividend = 8'd255; divisor = 8'd16;
    while (edge_cnt < acc + 9) @(negedge clk);
    start = 1'b0;
    drain();

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
